// File: rtl/morph_filter3x3.sv
// Streaming 3x3 binary morphology filter (erode/dilate, cross or square
// structuring element) for raster-order pixel streams of IMG_W x IMG_H.
//
// Handshake: an input beat is taken on a rising edge where in_valid && in_ready.
// in_ready is high in IDLE and RUN and low during FLUSH. The output side
// has no backpressure. out_valid is a one-cycle pulse per pixel, and
// out_sof/out_eof/out_pixel are meaningful only while out_valid is high.
module morph_filter3x3 #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_pixel,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  input  logic [1:0] mode,
  output logic       out_pixel,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eof,
  output logic       sof_err
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int LAST_B = NPIX + IMG_W;        // index of the final flush beat
  localparam int BW     = $clog2(LAST_B + 2);
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     b_cnt;                    // beats taken so far in this frame
  logic [CW-1:0]     cc;                       // column of the window centre
  logic [RW-1:0]     cr;                       // row of the window centre
  logic [1:0]        mode_q;                   // [0]=dilate, [1]=square
  logic [2*IMG_W+1:0] sr;                      // two line buffers + window taps
  logic [2*IMG_W+2:0] win;                     // sr plus the pixel of this beat
  logic              new_px, sof_beat, beat, center_valid, filt;
  logic              n_ok, s_ok, w_ok, e_ok, neutral;
  logic [8:0]        taps;

  // Beat qualification: sof beat in IDLE, any valid pixel in RUN, every FLUSH cycle
  always_comb begin
    sof_beat     = (state == IDLE) && in_valid && in_sof;
    beat         = sof_beat || ((state == RUN) && in_valid) || (state == FLUSH);
    new_px       = (state == FLUSH) ? 1'b0 : in_pixel;
    center_valid = beat && (state != IDLE) && (b_cnt >= BW'(IMG_W + 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sof_beat) state_nxt = RUN;
      RUN:     if (in_valid && (b_cnt == BW'(NPIX - 1))) state_nxt = FLUSH;
      FLUSH:   if (b_cnt == BW'(LAST_B)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: accept input except while flushing (and never under reset)
  always_comb begin
    in_ready = (state != FLUSH) && !rst;
  end

  // Beat counter, centre coordinates and per-frame mode latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_cnt  <= '0;
      cc     <= '0;
      cr     <= '0;
      mode_q <= 2'b00;
    end else if (sof_beat) begin
      b_cnt  <= BW'(1);
      cc     <= '0;
      cr     <= '0;
      mode_q <= mode;
    end else if (beat) begin
      b_cnt <= b_cnt + BW'(1);
      if (center_valid) begin
        if (cc == CW'(IMG_W - 1)) begin
          cc <= '0;
          cr <= cr + RW'(1);
        end else begin
          cc <= cc + CW'(1);
        end
      end
    end
  end

  // Pixel delay line; stale contents are harmless because padding masks them
  always_ff @(posedge clk) begin
    if (beat) sr <= win[2*IMG_W+1:0];
  end

  // Window taps with border padding; tap (r,c) sits (2-r)*IMG_W+(2-c) beats back
  always_comb begin
    win     = {sr, new_px};
    neutral = ~mode_q[0];
    n_ok    = (cr != '0);
    s_ok    = (cr != RW'(IMG_H - 1));
    w_ok    = (cc != '0);
    e_ok    = (cc != CW'(IMG_W - 1));
    taps    = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if ((r != 0 || n_ok) && (r != 2 || s_ok) && (c != 0 || w_ok) &&
            (c != 2 || e_ok) && (mode_q[1] || r == 1 || c == 1))
          taps[r*3+c] = win[(2-r)*IMG_W + (2-c)];
        else
          taps[r*3+c] = neutral;
      end
    end
    filt = mode_q[0] ? (|taps) : (&taps);
  end

  // Registered outputs, one cycle after the beat that completes the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pixel <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      out_valid <= center_valid;
      out_pixel <= center_valid && filt;
      out_sof   <= center_valid && (cr == '0) && (cc == '0);
      out_eof   <= center_valid && (cr == RW'(IMG_H - 1)) && (cc == CW'(IMG_W - 1));
      sof_err   <= (state == RUN) && in_valid && in_sof;
    end
  end

endmodule

// File: tb/tb_morph_filter3x3.sv
// Bench for morph_filter3x3 with an 8x8 frame: driver tasks push expected
// output pixels into a queue, a negedge monitor pops and compares them.
module tb_morph_filter3x3;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_pixel, in_valid, in_sof, in_ready;
  logic [1:0] mode;
  logic       out_pixel, out_valid, out_sof, out_eof, sof_err;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         beat_edge9 = 0;
  logic [2:0] exp_q[$];             // {pixel, sof, eof}
  bit         img [H][W];

  morph_filter3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_sof(in_sof), .in_ready(in_ready), .mode(mode), .out_pixel(out_pixel),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .sof_err(sof_err)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: neighbourhood reduction over the image with out-of-frame = neutral
  function automatic bit model_px(int i, int j, logic [1:0] m);
    bit dil = m[0];
    bit acc = !dil;
    bit v;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!m[1] && dr != 0 && dc != 0) continue;
        if (i + dr < 0 || i + dr >= H || j + dc < 0 || j + dc >= W) v = !dil;
        else v = img[i+dr][j+dc];
        acc = dil ? (acc | v) : (acc & v);
      end
    end
    return acc;
  endfunction

  task automatic fill(int kind);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        case (kind)
          0: img[i][j] = 1'b0;
          1: img[i][j] = 1'b1;
          default: img[i][j] = bit'($urandom_range(1));
        endcase
  endtask

  task automatic do_reset_mid;
    rst = 1'b1;
    #1;
    check("reset_outputs", {out_valid, out_pixel, out_sof, out_eof, sof_err, in_ready}, 6'b0);
    exp_q.delete();
    step;
    rst = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    step;
    // IDLE must discard non-sof beats; the monitor flags any output
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      in_pixel = 1'b1;
      check("idle_ready", in_ready, 1'b1);
      step;
    end
    in_valid = 1'b0;
  endtask

  // Driver: one frame with random gaps; optional mid-frame sof and abort
  task automatic send_frame(logic [1:0] m, int gap_pct, int err_at, int abort_at);
    int t;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        exp_q.push_back({model_px(i, j, m), 1'(i == 0 && j == 0), 1'(i == H-1 && j == W-1)});
    for (int k = 0; k < NPIX; k++) begin
      if (k == abort_at) begin
        do_reset_mid();
        return;
      end
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_sof   = 1'($urandom_range(1));
        in_pixel = 1'($urandom_range(1));
        mode     = 2'($urandom_range(3));
        step;
      end
      in_valid = 1'b1;
      in_pixel = img[k/W][k%W];
      in_sof   = (k == 0) || (k == err_at);
      mode     = (k == 0) ? m : 2'($urandom_range(3));
      t = 0;
      while (!in_ready && t < 20) begin
        step;
        t++;
      end
      if (t == 20) check("in_ready_timeout", 0, 1);
      if (k == W + 1) beat_edge9 = cyc + 1;
      step;
      check("sof_err", sof_err, 1'(k == err_at && k > 0));
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    t = 0;
    while (!in_ready && t < 100) begin
      t++;
      step;
    end
    check("flush_len", t, W + 1);
    check("eof_after_flush", {out_valid, out_eof}, 2'b11);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        check("out_pix_sof_eof", {out_pixel, out_sof, out_eof}, e);
        if (out_sof) check("first_out_latency", cyc, beat_edge9);
      end
    end
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  // Main sequence
  initial begin
    rst = 1'b1; in_pixel = 1'b0; in_valid = 1'b0; in_sof = 1'b0; mode = 2'b00;
    #1;
    check("reset_state", {out_valid, out_pixel, out_sof, out_eof, sof_err}, 5'b0);
    step;
    step;
    rst = 1'b0;
    step;
    check("ready_after_reset", in_ready, 1'b1);

    fill(0); img[3][3] = 1'b1;
    send_frame(2'b01, 0, -1, -1);
    send_frame(2'b11, 0, -1, -1);
    fill(0); img[0][0] = 1'b1;
    send_frame(2'b11, 0, -1, -1);
    fill(1);
    send_frame(2'b00, 0, -1, -1);
    send_frame(2'b10, 0, -1, -1);
    fill(0);
    send_frame(2'b11, 0, -1, -1);
    for (int i = 2; i <= 4; i++)
      for (int j = 2; j <= 4; j++) img[i][j] = 1'b1;
    send_frame(2'b10, 50, -1, -1);
    fill(2);
    send_frame(2'($urandom_range(3)), 30, 20, -1);
    fill(2);
    send_frame(2'($urandom_range(3)), 20, -1, 30);
    fill(2);
    send_frame(2'($urandom_range(3)), 0, -1, -1);
    fill(2);
    send_frame(2'($urandom_range(3)), 40, 45, -1);

    repeat (20) step;
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
